// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier control unit.
//   mult_state_e : sequencer states
//   MULT_WIDTH   : default operand width
//   cnt_width()  : iteration counter width for a given operand width
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_e;

  // One spare bit so the counter can step past WIDTH-1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the shift-add multiplier.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, count returns to 0
//   clr_i   : synchronous clear to 0 (wins over inc_i)
//   inc_i   : increment by one
//   last_o  : count equals Width-1 (final iteration)
module iter_counter
  import mult_pkg::*;
#(
  parameter int unsigned Width = MULT_WIDTH,
  parameter int unsigned CntW  = cnt_width(Width)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == LastCnt);

endmodule

// File: rtl/mult_ctrl.sv
// Control FSM for the lab2 shift-add multiplier datapath.
// Sequences CLEAR, then WIDTH ADD/SHIFT pairs, then HOLD until Run drops.
//   Clk, Reset_n      : clock, asynchronous active-low reset
//   Run               : start request (level, synchronized)
//   ClearA_LoadB      : clear A/X and load B while idle (level, synchronized)
//   M                 : current LSB of B
//   Clr_A, Ld_B, Add, Sub, Shift_En : datapath controls
//   Busy, Done        : sequence in progress / result valid in A:B
// Optional build macro MULT_CTRL_SIGNED_EN: the final iteration subtracts
// (Sub) instead of adding, giving a two's-complement product.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_A,
  output logic Ld_B,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  mult_state_e state_q, state_d;
  // Low for the first cycle after reset release so every output stays 0.
  logic armed_q, armed_d;

  logic cnt_clr;
  logic cnt_inc;
  logic cnt_last;

  iter_counter #(
    .Width(WIDTH)
  ) u_iter_counter (
    .clk_i (Clk),
    .rst_ni(Reset_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .last_o(cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    armed_d  = 1'b1;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    Clr_A    = 1'b0;
    Ld_B     = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (armed_q) begin
          // Run takes priority: no load pulse on the start cycle.
          if (Run) begin
            state_d = CLEAR;
          end else begin
            Clr_A = ClearA_LoadB;
            Ld_B  = ClearA_LoadB;
          end
        end
      end
      CLEAR: begin
        Clr_A   = 1'b1;
        Busy    = 1'b1;
        cnt_clr = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        Busy    = 1'b1;
`ifdef MULT_CTRL_SIGNED_EN
        // Final bit of B carries negative weight.
        Add     = M & ~cnt_last;
        Sub     = M & cnt_last;
`else
        Add     = M;
`endif
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        cnt_inc  = 1'b1;
        state_d  = cnt_last ? HOLD : ADD;
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

endmodule
